// File: rtl/id_operand_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : id_operand_stage                                           |
// | Description : Decode/operand-fetch stage. Holds the multi-port register  |
// |               file, the load-use interlock and the ID/EX pipeline        |
// |               register with a valid/ready handshake.                     |
// | Build macro : ID_WB_BYPASS_EN - same-cycle write-back is forwarded to    |
// |               the read ports; when undefined, a read that collides with  |
// |               a same-cycle write stalls one cycle instead.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module id_operand_stage #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int RLOG   = 5,
    parameter int NSRC   = 3,
    parameter int CTRL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NSRC*RLOG-1:0] in_rs,
    input  logic [NSRC-1:0]      in_rs_en,
    input  logic [RLOG-1:0]      in_rd,
    input  logic                 in_we,
    input  logic                 in_is_load,
    input  logic [CTRL_W-1:0]    in_ctrl,
    input  logic [XLEN-1:0]      in_imm,
    input  logic                 flush,
    input  logic                 wb_we,
    input  logic [RLOG-1:0]      wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NSRC*XLEN-1:0] out_src,
    output logic [RLOG-1:0]      out_rd,
    output logic                 out_we,
    output logic                 out_is_load,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [XLEN-1:0]      out_imm
);

    // Register file storage; entry 0 is never written and never read.
    logic [XLEN-1:0]      r_rf [NREG];

    // ID/EX pipeline register
    logic                 r_out_valid;
    logic [NSRC*XLEN-1:0] r_out_src;
    logic [RLOG-1:0]      r_out_rd;
    logic                 r_out_we;
    logic                 r_out_is_load;
    logic [CTRL_W-1:0]    r_out_ctrl;
    logic [XLEN-1:0]      r_out_imm;

    logic [NSRC*XLEN-1:0] w_rd_data;
    logic [NSRC-1:0]      w_haz_hit;
    logic [NSRC-1:0]      w_wb_hit;
    logic                 w_wb_write;
    logic                 w_hazard;
    logic                 w_wbstall;
    logic                 w_accept;

    assign w_wb_write = wb_we & (wb_rd != '0);

    // Per read port: index extraction, RF read, hazard and write-back match.
    generate
        for (genvar k = 0; k < NSRC; k++) begin : g_port
            logic [RLOG-1:0] w_idx;
            logic [XLEN-1:0] w_rf_val;

            assign w_idx        = in_rs[k*RLOG +: RLOG];
            assign w_rf_val     = (w_idx == '0) ? '0 : r_rf[w_idx];
            assign w_haz_hit[k] = in_rs_en[k] & (w_idx == r_out_rd);
            assign w_wb_hit[k]  = w_wb_write & (wb_rd == w_idx);
`ifdef ID_WB_BYPASS_EN
            assign w_rd_data[k*XLEN +: XLEN] = w_wb_hit[k] ? wb_data : w_rf_val;
`else
            assign w_rd_data[k*XLEN +: XLEN] = w_rf_val;
`endif
        end
    endgenerate

`ifdef ID_WB_BYPASS_EN
    // Write-through covers the collision, so no stall is ever needed.
    assign w_wbstall = 1'b0;
`else
    // Wait one cycle so the operand is read from the RF after the write lands.
    assign w_wbstall = |(w_wb_hit & in_rs_en);
`endif

    // Only loads create a use hazard; other producers are forwarded in EX.
    assign w_hazard = r_out_valid & r_out_is_load & r_out_we &
                      (r_out_rd != '0) & (|w_haz_hit);

    assign in_ready = ~flush & ~w_hazard & ~w_wbstall & (~r_out_valid | out_ready);
    assign w_accept = in_valid & in_ready;

    // Register file write port with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_wb_write) begin
            r_rf[wb_rd] <= wb_data;
        end
    end

    // ID/EX register: flush beats accept, accept beats drain, else hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid   <= 1'b0;
            r_out_src     <= '0;
            r_out_rd      <= '0;
            r_out_we      <= 1'b0;
            r_out_is_load <= 1'b0;
            r_out_ctrl    <= '0;
            r_out_imm     <= '0;
        end else if (flush) begin
            r_out_valid   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_src     <= w_rd_data;
            r_out_rd      <= in_rd;
            r_out_we      <= in_we;
            r_out_is_load <= in_is_load;
            r_out_ctrl    <= in_ctrl;
            r_out_imm     <= in_imm;
        end else if (r_out_valid && out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_src     = r_out_src;
    assign out_rd      = r_out_rd;
    assign out_we      = r_out_we;
    assign out_is_load = r_out_is_load;
    assign out_ctrl    = r_out_ctrl;
    assign out_imm     = r_out_imm;

endmodule
`default_nettype wire

// File: tb/tb_id_operand_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_id_operand_stage                                        |
// | Description : Self-checking bench for id_operand_stage. A reference RF   |
// |               model predicts operands; accepted instructions are queued  |
// |               and compared when they leave the ID/EX register.           |
// | Build macro : ID_WB_BYPASS_EN selects the expected collision behaviour.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_id_operand_stage;

    localparam int c_xlen = 32;
    localparam int c_rlog = 5;
    localparam int c_nsrc = 3;
    localparam int c_ctrl = 8;
    localparam int c_pw   = c_nsrc*c_xlen + c_rlog + 2 + c_ctrl + c_xlen;

    logic                     clk;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic [c_nsrc*c_rlog-1:0] in_rs;
    logic [c_nsrc-1:0]        in_rs_en;
    logic [c_rlog-1:0]        in_rd;
    logic                     in_we;
    logic                     in_is_load;
    logic [c_ctrl-1:0]        in_ctrl;
    logic [c_xlen-1:0]        in_imm;
    logic                     flush;
    logic                     wb_we;
    logic [c_rlog-1:0]        wb_rd;
    logic [c_xlen-1:0]        wb_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [c_nsrc*c_xlen-1:0] out_src;
    logic [c_rlog-1:0]        out_rd;
    logic                     out_we;
    logic                     out_is_load;
    logic [c_ctrl-1:0]        out_ctrl;
    logic [c_xlen-1:0]        out_imm;

    int errors = 0;
    int checks = 0;

    logic [c_pw-1:0]   sb[$];
    logic [c_xlen-1:0] model_rf [32];

    id_operand_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rs_en(in_rs_en), .in_rd(in_rd), .in_we(in_we),
        .in_is_load(in_is_load), .in_ctrl(in_ctrl), .in_imm(in_imm),
        .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
        .out_rd(out_rd), .out_we(out_we), .out_is_load(out_is_load),
        .out_ctrl(out_ctrl), .out_imm(out_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference register file: cleared by reset, r0 never written.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) model_rf[i] <= '0;
        end else if (wb_we && wb_rd != 5'd0) begin
            model_rf[wb_rd] <= wb_data;
        end
    end

    // Scoreboard: pop and compare on output fire, push on input accept.
    logic [c_pw-1:0]         m_exp;
    logic [c_pw-1:0]         m_got;
    logic [c_nsrc*c_xlen-1:0] m_src;
    logic [c_rlog-1:0]       m_idx;
    always @(negedge clk) begin
        if (rst && out_valid && out_ready && !flush) begin
            checks++;
            m_got = {out_src, out_rd, out_we, out_is_load, out_ctrl, out_imm};
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_output got=%h required=none", m_got);
            end else begin
                m_exp = sb.pop_front();
                if (m_got !== m_exp) begin
                    errors++;
                    $display("FAIL sb_payload got=%h required=%h", m_got, m_exp);
                end
            end
        end
        if (rst && in_valid && in_ready) begin
            for (int k = 0; k < c_nsrc; k++) begin
                m_idx = in_rs[k*c_rlog +: c_rlog];
                if (m_idx == 5'd0)
                    m_src[k*c_xlen +: c_xlen] = '0;
`ifdef ID_WB_BYPASS_EN
                else if (wb_we && wb_rd != 5'd0 && wb_rd == m_idx)
                    m_src[k*c_xlen +: c_xlen] = wb_data;
`endif
                else
                    m_src[k*c_xlen +: c_xlen] = model_rf[m_idx];
            end
            sb.push_back({m_src, in_rd, in_we, in_is_load, in_ctrl, in_imm});
        end
    end

    task automatic set_in(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [2:0] en, input logic [4:0] rd, input logic we,
                          input logic ld, input logic [7:0] ctrl, input logic [31:0] imm);
        in_valid   = 1'b1;
        in_rs      = {r2, r1, r0};
        in_rs_en   = en;
        in_rd      = rd;
        in_we      = we;
        in_is_load = ld;
        in_ctrl    = ctrl;
        in_imm     = imm;
    endtask

    task automatic send(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [2:0] en, input logic [4:0] rd, input logic we,
                        input logic ld, input logic [7:0] ctrl, input logic [31:0] imm);
        bit done = 0;
        int n = 0;
        set_in(r0, r1, r2, en, rd, we, ld, ctrl, imm);
        while (!done && n < 20) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout got=not_accepted required=accepted rd=%0d", rd);
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        wb_we     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_in(5'd1, 5'd2, 5'd3, 3'b111, 5'd9, 1'b1, 1'b1, 8'hFF, 32'hFFFF_FFFF);
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got=%b required=0", out_valid);
        end
        checks++;
        if ({out_src, out_rd, out_we, out_is_load, out_ctrl, out_imm} !== '0) begin
            errors++; $display("FAIL reset_payload got=%h required=0",
                               {out_src, out_rd, out_we, out_is_load, out_ctrl, out_imm});
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        rst       = 1'b1;
        out_ready = 1'b1;
        // Read every register back; the scoreboard expects zero throughout.
        for (int k = 0; k < 11; k++) begin
            send(5'(3*k+1), 5'(3*k+2), 5'(3*k+3), 3'b111, 5'd1, 1'b0, 1'b0, 8'(k), 32'(k));
        end
        drain();
    endtask

    task automatic test_write_read();
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        wb_we = 1'b0;
        send(5'd5, 5'd0, 5'd0, 3'b011, 5'd1, 1'b0, 1'b0, 8'h01, 32'h5);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_src[31:0] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wr_rd_src0 got=%b/%h required=1/deadbeef",
                               out_valid, out_src[31:0]);
        end
        checks++;
        if (out_src[63:32] !== 32'h0) begin
            errors++; $display("FAIL wr_rd_src1 got=%h required=0", out_src[63:32]);
        end
        drain();
    endtask

    task automatic test_load_use();
        set_in(5'd0, 5'd0, 5'd0, 3'b000, 5'd7, 1'b1, 1'b1, 8'h11, 32'h70);
        @(posedge clk); #1;
        set_in(5'd0, 5'd7, 5'd0, 3'b010, 5'd8, 1'b1, 1'b0, 8'h22, 32'h80);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL ld_use_stall got=%b required=0", in_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL ld_use_bubble got=%b required=0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL ld_use_resume got=%b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_rd !== 5'd8) begin
            errors++; $display("FAIL ld_use_issue got=%b/%0d required=1/8", out_valid, out_rd);
        end
        drain();
        // Same dependency through a disabled port must not stall.
        set_in(5'd0, 5'd0, 5'd0, 3'b000, 5'd7, 1'b1, 1'b1, 8'h33, 32'h71);
        @(posedge clk); #1;
        set_in(5'd0, 5'd7, 5'd0, 3'b000, 5'd8, 1'b1, 1'b0, 8'h44, 32'h81);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL ld_use_disabled got=%b required=1", in_ready);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_backpressure();
        set_in(5'd5, 5'd0, 5'd0, 3'b001, 5'd3, 1'b1, 1'b0, 8'hA5, 32'h1111_2222);
        @(posedge clk); #1;
        out_ready = 1'b0;
        set_in(5'd0, 5'd0, 5'd0, 3'b000, 5'd4, 1'b1, 1'b0, 8'h5A, 32'h3333_4444);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_in_ready cycle=%0d got=%b required=0", i, in_ready);
            end
            checks++;
            if ({out_valid, out_src, out_rd, out_ctrl, out_imm} !==
                {1'b1, 64'h0, 32'hDEAD_BEEF, 5'd3, 8'hA5, 32'h1111_2222}) begin
                errors++; $display("FAIL bp_hold cycle=%0d got=%h/%0d/%h/%h", i,
                                   out_src, out_rd, out_ctrl, out_imm);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got=%b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_rd !== 5'd4 || out_imm !== 32'h3333_4444) begin
            errors++; $display("FAIL bp_next got=%b/%0d/%h required=1/4/33334444",
                               out_valid, out_rd, out_imm);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_no_dup got=%b required=0", out_valid);
        end
        drain();
    endtask

    task automatic test_wb_same_cycle();
        wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_1234;
        set_in(5'd0, 5'd0, 5'd9, 3'b100, 5'd10, 1'b1, 1'b0, 8'h33, 32'h0);
        @(negedge clk);
`ifdef ID_WB_BYPASS_EN
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL wb_bypass_ready got=%b required=1", in_ready);
        end
        @(posedge clk); #1;
        wb_we = 1'b0; in_valid = 1'b0;
`else
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL wb_stall got=%b required=0", in_ready);
        end
        @(posedge clk); #1;
        wb_we = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL wb_stall_release got=%b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
`endif
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_src[95:64] !== 32'h0000_1234) begin
            errors++; $display("FAIL wb_src2 got=%b/%h required=1/00001234",
                               out_valid, out_src[95:64]);
        end
        drain();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_in(5'd5, 5'd0, 5'd0, 3'b001, 5'd12, 1'b1, 1'b0, 8'hC1, 32'h55);
        @(posedge clk); #1;
        set_in(5'd0, 5'd0, 5'd0, 3'b000, 5'd13, 1'b1, 1'b0, 8'hC2, 32'h66);
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_pre got=%b/%b required=1/0", out_valid, in_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_drop got=%b required=0", out_valid);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_incoming got=%b required=0", out_valid);
        end
        // Flush, reset and a write all in the same cycle: reset wins.
        out_ready = 1'b0;
        set_in(5'd5, 5'd0, 5'd0, 3'b001, 5'd14, 1'b1, 1'b1, 8'hF0, 32'hFFFF_0000);
        @(posedge clk); #1;
        flush = 1'b1; rst = 1'b0;
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h0000_CAFE;
        @(posedge clk); #1;
        flush = 1'b0; rst = 1'b1; wb_we = 1'b0; in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if ({out_valid, out_src, out_rd, out_we, out_is_load, out_ctrl, out_imm} !== '0) begin
            errors++; $display("FAIL flush_rst got=%b/%h required=0/0", out_valid, out_imm);
        end
        out_ready = 1'b1;
        send(5'd4, 5'd5, 5'd0, 3'b011, 5'd2, 1'b0, 1'b0, 8'h77, 32'h0);
        @(negedge clk);
        checks++;
        if (out_src[63:0] !== 64'h0) begin
            errors++; $display("FAIL rst_over_write got=%h required=0", out_src[63:0]);
        end
        @(posedge clk); #1;
        // Writes to r0 are discarded.
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        wb_we = 1'b0;
        send(5'd0, 5'd0, 5'd0, 3'b111, 5'd2, 1'b0, 1'b0, 8'h78, 32'h1);
        @(negedge clk);
        checks++;
        if (out_src !== '0) begin
            errors++; $display("FAIL r0_write got=%h required=0", out_src);
        end
        drain();
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_rs = '0; in_rs_en = '0; in_rd = '0;
        in_we = 1'b0; in_is_load = 1'b0; in_ctrl = '0; in_imm = '0;
        flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
        test_reset();
        test_write_read();
        test_load_use();
        test_backpressure();
        test_wb_same_cycle();
        test_flush();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_leftover got=%0d required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
